uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 10 +
 rtl/uart_rx.sv | 87 ++++++++
 tb/tb_uart_rx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and sizing constants
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, reset to the idle-high level
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) {q, m} <= reset ? 2'b11 : {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, 8N1 by default, 8E1 (even parity) when UART_RX_PARITY_EN is defined
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  input  logic                 clear_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic rx_s, bit_tick, half_tick, data_tick, stop_smp, par_bad, good, bad_stop, bad_par;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
  uart_rx_sync sync (.clk(clk), .reset(reset), .d(rx_pin), .q(rx_s));
  assign bit_tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign half_tick = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign data_tick = state == DATA && bit_tick;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk)
    if (reset) par_bit <= 1'b0;
    else if (state == PARITY && bit_tick) par_bit <= rx_s;
  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad = 1'b0;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = half_tick ? (rx_s ? IDLE : DATA) : START;
      DATA:      state_n = data_tick && bit_idx == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:    state_n = bit_tick ? STOP : PARITY;
`endif
      STOP:      state_n = bit_tick ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    stop_smp = state == STOP && bit_tick;
    good = stop_smp && rx_s && !par_bad;
    bad_stop = stop_smp && !rx_s;
    bad_par = stop_smp && rx_s && par_bad;
  end
  // a byte completing together with clear_rx keeps rx_ready set and suppresses overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_ready <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      cnt <= (state_n != state || bit_tick || state == IDLE || state == WAIT_HIGH) ? '0 : cnt + 1'b1;
      bit_idx <= state_n != state ? '0 : bit_idx + 3'(data_tick);
      shift <= data_tick ? {rx_s, shift[DATA_BITS-1:1]} : shift;
      rx_data <= good ? shift : rx_data;
      rx_valid <= good;
      frame_err <= bad_stop;
      parity_err <= bad_par;
      rx_ready <= good || (rx_ready && !clear_rx);
      overrun_err <= !clear_rx && (overrun_err || (good && rx_ready));
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level model of the receiver
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 3 + CPB / 2 + (9 + PB) * CPB;
  logic clk = 1'b0, reset = 1'b1, rx_pin = 1'b1, clear_rx = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready, frame_err, overrun_err, parity_err;
  int total = 0, bad = 0, cyc = 0, n_valid = 0, n_ferr = 0, n_perr = 0, last_valid = -1;
  int g_v, g_f, g_p;
  logic [7:0] m_data = 8'h00, rb;
  logic m_ready = 1'b0, m_ovr = 1'b0, rs, rc;
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx_pin(rx_pin), .clear_rx(clear_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid = cyc;
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    rx_pin = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic par, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (PB == 1) hold(par, CPB);
    hold(stop, stop ? CPB : CPB + 40);
    hold(1'b1, 6);
  endtask
  task automatic frame(input logic [7:0] b, input logic stop, input logic flip, input logic clr);
    int v0, f0, p0, t0;
    logic good;
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
    good = stop && !(PB == 1 && flip);
    fork
      send(b, stop, (^b) ^ flip, t0);
      if (clr) begin
        @(posedge clk);
        #1;
        repeat (LAT - 1) @(posedge clk);
        #1 clear_rx = 1'b1;
        @(posedge clk);
        #1 clear_rx = 1'b0;
      end
    join
    if (good) begin
      m_ovr = clr ? 1'b0 : (m_ovr | m_ready);
      m_data = b;
      m_ready = 1'b1;
    end
    check("valid_pulses", n_valid - v0, 32'(good));
    check("frame_err_pulses", n_ferr - f0, 32'(!stop));
    check("parity_err_pulses", n_perr - p0, 32'(stop && PB == 1 && flip));
    if (good) check("valid_latency", last_valid - t0, LAT);
    check("rx_data", rx_data, m_data);
    check("rx_ready", rx_ready, m_ready);
    check("overrun_err", overrun_err, m_ovr);
  endtask
  task automatic do_clear();
    @(posedge clk);
    #1 clear_rx = 1'b1;
    @(posedge clk);
    #1 clear_rx = 1'b0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    check("clear_ready", rx_ready, m_ready);
    check("clear_overrun", overrun_err, m_ovr);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ready", rx_ready, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_overrun", overrun_err, 0);
    check("rst_perr", parity_err, 0);
    reset = 1'b0;
    g_v = n_valid;
    g_f = n_ferr;
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("glitch_valid", n_valid - g_v, 0);
    check("glitch_ferr", n_ferr - g_f, 0);
    frame(8'h3C, 1'b0, 1'b0, 1'b0);
    frame(8'h81, 1'b1, 1'b0, 1'b0);
    do_clear();
    frame(8'hA5, 1'b1, 1'b0, 1'b0);
    do_clear();
    frame(8'h11, 1'b1, 1'b0, 1'b0);
    frame(8'h22, 1'b1, 1'b0, 1'b0);
    do_clear();
    frame(8'h33, 1'b1, 1'b0, 1'b0);
    frame(8'h55, 1'b1, 1'b0, 1'b1);
    frame(8'h07, 1'b1, 1'b1, 1'b0);
    frame(8'h07, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      rs = $urandom_range(0, 3) != 0;
      rc = rs && 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_clear();
      frame(rb, rs, 1'($urandom_range(0, 1)), rc);
    end
    g_v = n_valid;
    g_f = n_ferr;
    g_p = n_perr;
    hold(1'b0, 60);
    reset = 1'b1;
    hold(1'b0, 2);
    reset = 1'b0;
    m_data = 8'h00;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    hold(1'b1, 200);
    check("midrst_valid", n_valid - g_v, 0);
    check("midrst_ferr", n_ferr - g_f, 0);
    check("midrst_perr", n_perr - g_p, 0);
    check("midrst_data", rx_data, m_data);
    check("midrst_ready", rx_ready, m_ready);
    frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
